// File: rtl/moving_avg_pkg.sv
// Shared types and derivation helpers for the boxcar moving-average filter.
// Provides the FILL/RUN state encoding, window length and running-sum width.
// Optional rounding in the filter is selected by macro MOVING_AVG_ROUND_EN.
package moving_avg_pkg;

  // Default configuration: 8-bit samples, 8-point window.
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LOG2_TAPS = 3;

  // FILL until the window has seen TAPS samples, then RUN until reset.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Window length is always a power of two so the pointer wraps naturally.
  function automatic int taps_f(input int log2_taps);
    return 1 << log2_taps;
  endfunction

  // Running sum needs LOG2_TAPS guard bits above the sample width:
  // |sum| <= TAPS * 2^(DATA_W-1) fits exactly in DATA_W+LOG2_TAPS signed bits.
  function automatic int sum_w_f(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

endpackage

// File: rtl/moving_avg_ring.sv
// Circular sample store for the moving-average window.
// The entry about to be overwritten (the oldest sample) is presented combinationally.
// Writes advance the pointer; asynchronous reset zeroes every entry and the pointer.
module moving_avg_ring
  import moving_avg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] oldest_o
);

  localparam int TAPS = taps_f(LOG2_TAPS);

  logic [DATA_W-1:0]    buf_q [TAPS];
  logic [LOG2_TAPS-1:0] wr_ptr_q;
  logic [LOG2_TAPS-1:0] wr_ptr_d;

  // Pointer advances by one per write and wraps modulo TAPS for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + LOG2_TAPS'(1);
    end
  end

  // Store the new sample over the oldest one; clear everything on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else begin
      if (wr_en_i) begin
        buf_q[wr_ptr_q] <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // The slot under the write pointer holds the sample leaving the window.
  assign oldest_o = buf_q[wr_ptr_q];

endmodule

// File: rtl/moving_avg_filter.sv
// Boxcar moving average over 2^LOG2_TAPS signed samples; floor shift, or
// round-half-up with clamp when MOVING_AVG_ROUND_EN is defined. Latency 1 cycle.
// Single output register: in_ready = !out_valid || out_ready, full rate when drained.
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // Derived locally so it can never be overridden narrower than required.
  localparam int SUM_W = sum_w_f(DATA_W, LOG2_TAPS);
  // Fill counter value on the accept that completes the first window.
  localparam logic [LOG2_TAPS-1:0] LAST_FILL = '1;

  state_e                  state_q, state_d;
  logic [LOG2_TAPS-1:0]    fill_cnt_q, fill_cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;

  logic                    accept;
  logic                    load;
  logic [DATA_W-1:0]       oldest;
  logic signed [SUM_W-1:0] in_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic signed [SUM_W-1:0] new_sum;
  logic [DATA_W-1:0]       avg;

  moving_avg_ring #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_data_i (in_data),
    .oldest_o  (oldest)
  );

  // A stalled output register blocks intake, so in_data is ignored while held.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // One add and one subtract per sample, all sign-extended to the sum width.
  assign in_ext  = {{LOG2_TAPS{in_data[DATA_W-1]}}, in_data};
  assign old_ext = {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest};
  assign new_sum = sum_q + in_ext - old_ext;

`ifdef MOVING_AVG_ROUND_EN
  logic [DATA_W:0] rnd;

  // Adding half an LSB before the shift carries into the kept bits exactly when
  // bit LOG2_TAPS-1 is set, so the SUM_W+1-bit add reduces to adding that bit
  // to the one-bit-extended quotient. Only +max can round past the range.
  always_comb begin
    rnd = {new_sum[SUM_W-1], new_sum[SUM_W-1:LOG2_TAPS]}
        + {{DATA_W{1'b0}}, new_sum[LOG2_TAPS-1]};
    if (rnd[DATA_W] != rnd[DATA_W-1]) begin
      avg = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      avg = rnd[DATA_W-1:0];
    end
  end
`else
  // Arithmetic shift by LOG2_TAPS, floor toward -inf: just the upper sum bits.
  assign avg = new_sum[SUM_W-1:LOG2_TAPS];
`endif

  // FILL counts accepts until the window is full; RUN emits on every accept.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    load       = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (fill_cnt_q == LAST_FILL) begin
            state_d = RUN;
            load    = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + LOG2_TAPS'(1);
          end
        end
      end
      RUN: begin
        load = accept;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Running sum tracks the window contents on every accept.
  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = new_sum;
    end
  end

  // A new average wins over a pop; otherwise a pop empties the register.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = avg;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // All state registers; reset discards any pending output and restarts FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter (8-point window, 8-bit samples).
// Reference keeps the last accepted samples in a queue and takes their mean.
// Honours MOVING_AVG_ROUND_EN for the expected rounding mode.
`timescale 1ns/1ps
module tb_moving_avg_filter;

  localparam int DATA_W    = 8;
  localparam int LOG2_TAPS = 3;
  localparam int TAPS      = 8;
  localparam int MAX_POS   = 127;

`ifdef MOVING_AVG_ROUND_EN
  localparam int EXP_NEG1    = 0;
  localparam int EXP_55      = 7;
  localparam int EXP_MIDWAY  = 0;
  localparam int EXP_POSTRST = 5;
`else
  localparam int EXP_NEG1    = -1;
  localparam int EXP_55      = 6;
  localparam int EXP_MIDWAY  = -1;
  localparam int EXP_POSTRST = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: accepted samples since reset, and expected output register.
  int hist[$];
  int acc_cnt = 0;
  bit exp_ov  = 1'b0;
  int exp_od  = 0;

  always #5 clk = ~clk;

  moving_avg_filter #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mean of the last TAPS accepted samples, floor or round-half-up with clamp.
  function automatic int ref_avg();
    int s = 0;
    int q;
    foreach (hist[i]) s += hist[i];
`ifdef MOVING_AVG_ROUND_EN
    s += TAPS / 2;
`endif
    q = s / TAPS;
    if ((s % TAPS) != 0 && s < 0) q--;
    if (q > MAX_POS) q = MAX_POS;
    return q;
  endfunction

  // One clock: drive, check outputs mid-cycle, then advance the reference.
  task automatic cycle(input bit v, input int d, input bit r);
    bit rdy;
    in_valid  = v;
    in_data   = d[DATA_W-1:0];
    out_ready = r;
    @(negedge clk);
    rdy = !exp_ov || r;
    chk("in_ready", in_ready, int'(rdy));
    chk("out_valid", out_valid, int'(exp_ov));
    if (exp_ov) chk("out_data", $signed(out_data), exp_od);
    @(posedge clk);
    #1;
    if (v && rdy) begin
      hist.push_back(d);
      if (hist.size() > TAPS) void'(hist.pop_front());
      acc_cnt++;
      if (acc_cnt >= TAPS) begin
        exp_ov = 1'b1;
        exp_od = ref_avg();
      end else if (r) begin
        exp_ov = 1'b0;
      end
    end else if (r) begin
      exp_ov = 1'b0;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    hist.delete();
    acc_cnt = 0;
    exp_ov  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill then steady state with a constant input.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 10, 1'b1);
      chk("fill_no_output", out_valid, 0);
    end
    cycle(1'b1, 10, 1'b1);
    chk("fill_first_valid", out_valid, 1);
    chk("fill_first_avg", $signed(out_data), 10);
    cycle(1'b1, 10, 1'b1);
    chk("steady_avg", $signed(out_data), 10);

    // Sign handling and floor/round of small fractions.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 0, 1'b1);
    cycle(1'b1, -1, 1'b1);
    chk("neg_one_eighth", $signed(out_data), EXP_NEG1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 7, 1'b1);
    chk("all_sevens", $signed(out_data), 7);
    cycle(1'b1, 6, 1'b1);
    chk("sum_55", $signed(out_data), EXP_55);
    for (int i = 0; i < 7; i++) cycle(1'b1, 6, 1'b1);
    chk("all_sixes", $signed(out_data), 6);

    // Extremes of the sample range.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, -128, 1'b1);
    chk("all_min", $signed(out_data), -128);
    for (int i = 0; i < 4; i++) cycle(1'b1, 127, 1'b1);
    chk("half_max_half_min", $signed(out_data), EXP_MIDWAY);
    for (int i = 0; i < 4; i++) cycle(1'b1, 127, 1'b1);
    chk("all_max", $signed(out_data), 127);

    // Backpressure: output held, intake blocked, then pop and push together.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 50, 1'b0);
      chk("stall_data_held", $signed(out_data), 127);
      chk("stall_in_ready", in_ready, 0);
    end
    cycle(1'b1, 50, 1'b1);
    chk("release_avg", $signed(out_data), 117);
    for (int i = 0; i < 4; i++) cycle(1'b1, 50, 1'b1);

    // Reset in the middle of RUN restarts the fill.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 3 * i - 20, 1'b1);
    chk("pre_reset_valid", out_valid, 1);
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, i, 1'b1);
      chk("refill_no_output", out_valid, 0);
    end
    cycle(1'b1, 8, 1'b1);
    chk("refill_avg", $signed(out_data), EXP_POSTRST);

    // Random traffic on both handshakes.
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
